// File: rtl/forward_sel_tracker.sv
// Operand-forwarding controller: tracks destination tags of EX and MEM, registers
// the EX operand-mux selects and flags load-use hazards for the instruction in ID.
module forward_sel_tracker #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_use_rs1,
    input  logic                      id_use_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      stall,
    input  logic                      flush,
    output logic [1:0]                ex_forward_a,
    output logic [1:0]                ex_forward_b,
    output logic                      load_use_hazard
);

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        logic                      mem_read;
    } ex_tag_t;

    // Selects are resolved as an instruction enters EX, when its producers sit in
    // EX and MEM; by the time a producer reaches WB its consumer has already
    // captured select 10, so no WB tag is ever consulted and none is stored.
    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
    } mem_tag_t;

    ex_tag_t  ex_tag, id_tag;
    mem_tag_t mem_tag, mem_next;
    fwd_sel_t sel_a, sel_b;
    logic     ex_live, mem_live, ex_bubble;

    assign ex_live   = ex_tag.valid  & ex_tag.reg_write  & (ex_tag.rd  != '0);
    assign mem_live  = mem_tag.valid & mem_tag.reg_write & (mem_tag.rd != '0);
    assign ex_bubble = flush | stall | ~id_valid;
    assign id_tag    = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

    assign load_use_hazard = id_valid & ex_live & ex_tag.mem_read &
                             ((id_use_rs1 & (ex_tag.rd == id_rs1)) |
                              (id_use_rs2 & (ex_tag.rd == id_rs2)));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
        mem_next = '0;
        if (!flush) begin
            mem_next = '{valid: ex_tag.valid, rd: ex_tag.rd, reg_write: ex_tag.reg_write};
        end

        // The newer producer (currently in EX) takes priority over the one in MEM.
        sel_a = FWD_RF;
        if (id_use_rs1 && ex_live && ex_tag.rd == id_rs1) begin
            sel_a = FWD_MEM;
        end else if (id_use_rs1 && mem_live && mem_tag.rd == id_rs1) begin
            sel_a = FWD_WB;
        end

        sel_b = FWD_RF;
        if (id_use_rs2 && ex_live && ex_tag.rd == id_rs2) begin
            sel_b = FWD_MEM;
        end else if (id_use_rs2 && mem_live && mem_tag.rd == id_rs2) begin
            sel_b = FWD_WB;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            // NOTE: the tags are a handful of flops, so they are cleared whole rather than valid bits only.
            ex_tag       <= '0;
            mem_tag      <= '0;
            ex_forward_a <= FWD_RF;
            ex_forward_b <= FWD_RF;
        end else begin
            mem_tag <= mem_next;
            if (ex_bubble) begin
                ex_tag       <= '0;
                ex_forward_a <= FWD_RF;
                ex_forward_b <= FWD_RF;
            end else begin
                ex_tag       <= id_tag;
                ex_forward_a <= sel_a;
                ex_forward_b <= sel_b;
            end
        end
    end

endmodule
